// File: rtl/ldpc_phase_scheduler.sv
// Sequencing controller for the LDPC decoder address counter: alternating CN/VN
// sweeps with pipeline-drain gaps, a per-iteration syndrome check and an iteration limit.
module ldpc_phase_scheduler #(
  parameter int unsigned CNT_W    = 13,
  parameter int unsigned ITER_W   = 6,
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  cn_len,
  input  logic [CNT_W-1:0]  vn_len,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              syndrome_ok,
  input  logic [CNT_W-1:0]  cnt_val,
  output logic              cnt_en,
  output logic              cnt_clr,
  output logic [1:0]        phase,
  output logic [ITER_W-1:0] iter,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              cfg_err
);

  localparam int unsigned DRN_W = $clog2(PIPE_LAT + 1);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CN_RUN,
    CN_DRAIN,
    VN_RUN,
    VN_DRAIN,
    CHECK,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cn_len_q;
  logic [CNT_W-1:0]  vn_len_q;
  logic [ITER_W-1:0] max_iter_q;
  logic [DRN_W-1:0]  drain_cnt;

  logic [CNT_W-1:0]  cn_last;
  logic [CNT_W-1:0]  vn_last;
  logic [ITER_W-1:0] iter_next;

  assign cn_last   = cn_len_q - CNT_W'(1);
  assign vn_last   = vn_len_q - CNT_W'(1);
  assign iter_next = iter + ITER_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      iter       <= '0;
      converged  <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      drain_cnt  <= '0;
      cn_len_q   <= '0;
      vn_len_q   <= '0;
      max_iter_q <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cn_len != '0 && vn_len != '0 && max_iter != '0) begin
              cn_len_q   <= cn_len;
              vn_len_q   <= vn_len;
              max_iter_q <= max_iter;
              iter       <= '0;
              converged  <= 1'b0;
              state      <= CN_RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        CN_RUN: begin
          if (cnt_val == cn_last) begin
            drain_cnt <= '0;
            state     <= CN_DRAIN;
          end
        end
        CN_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= VN_RUN;
          else drain_cnt <= drain_cnt + DRN_W'(1);
        end
        VN_RUN: begin
          if (cnt_val == vn_last) begin
            drain_cnt <= '0;
            state     <= VN_DRAIN;
          end
        end
        VN_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= CHECK;
          else drain_cnt <= drain_cnt + DRN_W'(1);
        end
        CHECK: begin
          iter <= iter_next;
          if (syndrome_ok) begin
            converged <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end else if (iter_next == max_iter_q) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= CN_RUN;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Counter clear is asserted only on the first drain cycle so the counter rests at 0 for the next sweep.
  always_comb begin
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    phase   = 2'd0;
    busy    = 1'b1;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        busy    = 1'b0;
      end
      CN_RUN: begin
        cnt_en = 1'b1;
        phase  = 2'd1;
      end
      CN_DRAIN: begin
        cnt_clr = (drain_cnt == '0);
        phase   = 2'd1;
      end
      VN_RUN: begin
        cnt_en = 1'b1;
        phase  = 2'd2;
      end
      VN_DRAIN: begin
        cnt_clr = (drain_cnt == '0);
        phase   = 2'd2;
      end
      CHECK:   phase = 2'd3;
      DONE:    cnt_clr = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldpc_phase_scheduler.sv
// Scoreboard bench for ldpc_phase_scheduler: a per-cycle expected trace is built from
// sweep/drain/check segment rules and compared against the DUT by an independent monitor.
module tb_ldpc_phase_scheduler;

  localparam int unsigned CNT_W    = 13;
  localparam int unsigned ITER_W   = 6;
  localparam int unsigned PIPE_LAT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  cn_len = '0;
  logic [CNT_W-1:0]  vn_len = '0;
  logic [ITER_W-1:0] max_iter = '0;
  logic              syndrome_ok = 1'b0;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_en, cnt_clr, busy, done, converged, cfg_err;
  logic [1:0]        phase;
  logic [ITER_W-1:0] iter;

  ldpc_phase_scheduler #(
    .CNT_W   (CNT_W),
    .ITER_W  (ITER_W),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cn_len     (cn_len),
    .vn_len     (vn_len),
    .max_iter   (max_iter),
    .syndrome_ok(syndrome_ok),
    .cnt_val    (cnt_val),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .phase      (phase),
    .iter       (iter),
    .busy       (busy),
    .done       (done),
    .converged  (converged),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  // External address counter driven by the scheduler's enable/clear.
  logic [CNT_W-1:0] counter = '0;
  assign cnt_val = counter;
  always @(posedge clk) begin
    if (cnt_clr) counter <= '0;
    else if (cnt_en) counter <= counter + CNT_W'(1);
  end

  typedef struct packed {
    logic [1:0]        phase;
    logic              en;
    logic              clr;
    logic              busy;
    logic              done;
    logic              conv;
    logic              cfg;
    logic [ITER_W-1:0] iter;
  } obs_t;

  typedef struct {
    obs_t o;
    logic synd;
  } step_t;

  obs_t              sb[$];
  step_t             plan[$];
  int unsigned       n_checks = 0;
  int unsigned       n_errors = 0;
  logic [ITER_W-1:0] idle_iter = '0;
  logic              idle_conv = 1'b0;
  logic [ITER_W-1:0] plan_iter;
  logic              plan_conv;
  logic              mon_on = 1'b0;
  obs_t              act, exp_o;

  always @(negedge clk) begin
    if (mon_on) begin
      act = {phase, cnt_en, cnt_clr, busy, done, converged, cfg_err, iter};
      if (sb.size() != 0) exp_o = sb.pop_front();
      else exp_o = {2'd0, 1'b0, 1'b1, 1'b0, 1'b0, idle_conv, 1'b0, idle_iter};
      n_checks++;
      if (act !== exp_o) begin
        n_errors++;
        $display("FAIL outputs t=%0t actual: phase=%0d en=%0b clr=%0b busy=%0b done=%0b conv=%0b cfg=%0b iter=%0d required: phase=%0d en=%0b clr=%0b busy=%0b done=%0b conv=%0b cfg=%0b iter=%0d",
                 $time, act.phase, act.en, act.clr, act.busy, act.done, act.conv, act.cfg, act.iter,
                 exp_o.phase, exp_o.en, exp_o.clr, exp_o.busy, exp_o.done, exp_o.conv, exp_o.cfg, exp_o.iter);
      end
      if (done === 1'b1 && busy !== 1'b1) begin
        n_errors++;
        $display("FAIL done-without-busy t=%0t actual: done=%0b busy=%0b required: busy=1",
                 $time, done, busy);
      end
    end
  end

  function automatic step_t mk(input logic [1:0] ph, input logic en, input logic clr,
                               input logic dn, input logic cv,
                               input logic [ITER_W-1:0] it, input logic s);
    step_t r;
    r.o    = {ph, en, clr, 1'b1, dn, cv, 1'b0, it};
    r.synd = s;
    return r;
  endfunction

  // Reference model: one trace entry per cycle after the accepted start.
  // smode: 0 = syndrome never ok, 1 = random, 2 = ok at the first check.
  task automatic build_plan(input int unsigned cn, input int unsigned vn,
                            input int unsigned mx, input int unsigned smode);
    logic [ITER_W-1:0] it;
    logic              cv;
    logic              fin;
    logic              s;
    plan.delete();
    it  = '0;
    cv  = 1'b0;
    fin = 1'b0;
    while (!fin) begin
      for (int unsigned j = 0; j < cn; j++)
        plan.push_back(mk(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, it, 1'($urandom_range(0, 1))));
      for (int unsigned j = 0; j < PIPE_LAT; j++)
        plan.push_back(mk(2'd1, 1'b0, (j == 0), 1'b0, 1'b0, it, 1'($urandom_range(0, 1))));
      for (int unsigned j = 0; j < vn; j++)
        plan.push_back(mk(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, it, 1'($urandom_range(0, 1))));
      for (int unsigned j = 0; j < PIPE_LAT; j++)
        plan.push_back(mk(2'd2, 1'b0, (j == 0), 1'b0, 1'b0, it, 1'($urandom_range(0, 1))));
      s = (smode == 0) ? 1'b0 : (smode == 2) ? 1'b1 : ($urandom_range(0, 3) == 0);
      plan.push_back(mk(2'd3, 1'b0, 1'b0, 1'b0, 1'b0, it, s));
      it = it + ITER_W'(1);
      if (s) begin
        cv  = 1'b1;
        fin = 1'b1;
      end else if (it == ITER_W'(mx)) begin
        fin = 1'b1;
      end
    end
    plan.push_back(mk(2'd0, 1'b0, 1'b1, 1'b1, cv, it, 1'b0));
    plan_iter = it;
    plan_conv = cv;
  endtask

  // Each driver task begins and ends 1 time unit after a rising edge.
  task automatic idle(input int unsigned n);
    repeat (n) begin
      syndrome_ok = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input int unsigned cn, input int unsigned vn, input int unsigned mx,
                     input int unsigned smode, input int unsigned abort_at,
                     input int unsigned busy_start_at);
    build_plan(cn, vn, mx, smode);
    cn_len   = CNT_W'(cn);
    vn_len   = CNT_W'(vn);
    max_iter = ITER_W'(mx);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    cn_len   = CNT_W'($urandom);
    vn_len   = CNT_W'($urandom);
    max_iter = ITER_W'($urandom);
    foreach (plan[i]) sb.push_back(plan[i].o);
    idle_iter = plan_iter;
    idle_conv = plan_conv;
    for (int unsigned k = 0; k < plan.size(); k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k + 1 == abort_at) begin
        reset       = 1'b1;
        syndrome_ok = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        sb.delete();
        idle_iter = '0;
        idle_conv = 1'b0;
        return;
      end
      syndrome_ok = plan[k].synd;
      start       = (k + 1 == busy_start_at);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic reject(input int unsigned cn, input int unsigned vn, input int unsigned mx);
    cn_len   = CNT_W'(cn);
    vn_len   = CNT_W'(vn);
    max_iter = ITER_W'(mx);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back({2'd0, 1'b0, 1'b1, 1'b0, 1'b0, idle_conv, 1'b1, idle_iter});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(6);
    run(5, 3, 2, 0, 0, 0);
    idle(3);
    run(5, 3, 2, 2, 0, 0);
    idle(2);
    reject(5, 0, 2);
    idle(2);
    reject(0, 3, 2);
    reject(5, 3, 0);
    idle(1);
    run(1, 1, 1, 0, 0, 0);
    run(5, 3, 2, 0, 0, 11);
    idle(2);
    run(5, 3, 2, 0, 3, 0);
    idle(2);
    run(5, 3, 2, 1, 0, 0);
    run(8191, 2, 1, 0, 0, 0);
    idle(2);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        reject($urandom_range(0, 3), 0, $urandom_range(0, 3));
      end else if ($urandom_range(0, 9) == 0) begin
        run($urandom_range(2, 10), $urandom_range(1, 10), $urandom_range(1, 4), 1,
            $urandom_range(1, 2), 0);
      end else begin
        run($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 4), 1, 0,
            $urandom_range(0, 40));
      end
      idle($urandom_range(0, 3));
    end
    idle(4);
    if (n_checks == 0) begin
      n_errors++;
      $display("FAIL no checks executed: actual n_checks=%0d required >0", n_checks);
    end
    if (n_errors != 0) $display("FAIL: %0d errors", n_errors);
    else $display("PASS");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
